fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch queue between the system bus and the decoder. Issues line-sized read requests, collects response beats into a circular byte buffer and presents a fixed-width byte window plus its RIP to the decoder. The decoder consumes a variable number of bytes per cycle. Generalises the in-core fetch buffer with configurable line, beat, depth and window sizes, sub-beat entry alignment, and redirect/flush with discard of in-flight lines.

## Interface
- BEAT_BYTES, 8: bytes per response beat; power of two.
- LINE_BYTES, 64: bytes per bus request; power of two, multiple of BEAT_BYTES.
- DEPTH_BYTES, 128: buffer capacity; power of two, at least 2*LINE_BYTES.
- WINDOW_BYTES, 15: decoder window width; at most DEPTH_BYTES-LINE_BYTES.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- entry  in  64  start RIP, taken while reset is high.
- req_valid  out  1  read request; held until req_ack.
- req_addr  out  64  line-aligned request address.
- req_ack  in  1  bus accepted the request.
- resp_valid  in  1  response beat present.
- resp_data  in  8*BEAT_BYTES  beat; byte i is at [8i+:8].
- resp_ack  out  1  equals resp_valid (combinational).
- redirect_valid  in  1  flush and restart at redirect_rip.
- redirect_rip  in  64  new fetch RIP.
- window  out  8*WINDOW_BYTES  bytes at read pointer, byte i at [8i+:8], wrapping across buffer end.
- window_valid  out  1  count >= WINDOW_BYTES.
- window_rip  out  64  RIP of window byte 0.
- consume  in  $clog2(WINDOW_BYTES+1)  bytes retired this cycle; honoured only when window_valid.
- count  out  $clog2(DEPTH_BYTES)+1  valid bytes in buffer.

## Operation
- Storage: DEPTH_BYTES byte ring. wr_ptr and rd_ptr are $clog2(DEPTH_BYTES)+1 bits wide. count = wr_ptr - rd_ptr modulo that width. Full when count == DEPTH_BYTES.
- Bus FSM states: IDLE, REQ, WAIT, ACTIVE.
  - IDLE -> REQ when DEPTH_BYTES - count >= LINE_BYTES. On entry, req_addr = fetch_addr & ~(LINE_BYTES-1).
  - REQ holds req_valid=1 and a stable req_addr until req_ack, then -> WAIT.
  - WAIT -> ACTIVE on the first beat.
  - ACTIVE -> IDLE after the LINE_BYTES/BEAT_BYTES-th beat. The beat counter decides line end; resp_valid dropping does not. fetch_addr advances by LINE_BYTES at line end.
- Skip: the first line after reset or redirect discards beats wholly below the beat containing the target RIP. The beat containing the RIP is written whole. On that write, rd_ptr additionally advances by rip mod BEAT_BYTES (pending sub_skip register). Skipped bytes never count.
- Write: each kept beat is written at wr_ptr; wr_ptr += BEAT_BYTES.
- Consume: when window_valid, rd_ptr += consume and window_rip += consume. consume > WINDOW_BYTES is illegal (assertion).
- Simultaneous beat write and consume: both apply in the same cycle; count reflects both.
- Redirect (highest priority):
  - Same cycle: wr_ptr = rd_ptr = 0, window_rip = fetch_addr = redirect_rip, sub_skip = redirect_rip mod BEAT_BYTES. Any concurrent consume and beat write are ignored.
  - In REQ/WAIT/ACTIVE, a drop flag is set. Remaining beats of the current line are acked and discarded. A pending req stays asserted with its old address until acked.
  - New request only from IDLE after the drop completes. Redirect in IDLE simply restarts.

## Timing
- Reset values: req_valid 0, req_addr 0, count 0, window_valid 0, buffer bytes 0, window 0, window_rip = entry, FSM IDLE, drop 0.
- First req_valid: the cycle after reset deasserts.
- Beat-to-count latency: 1 cycle. window_valid is combinational from count.
- A full line with sub_skip = 0 yields window_valid 1 cycle after the 2nd beat, given WINDOW_BYTES <= 2*BEAT_BYTES.
- Reset asserted mid-line: everything returns to reset values immediately; later beats of the line are the bus's responsibility.

## Structure
- Package fetch_pkg: FSM state enum and the beats-per-line and pointer-width localparam helpers.
- Sub-module fetch_ring: byte ring storage with beat write port and wrapped WINDOW_BYTES read. fetch_queue owns the FSM, pointers and RIP.

## Test plan
- Reset with entry=0x1000. First req_addr=0x1000. Eight beats of bytes 0x00..0x3F -> count 64, window bytes 0x00..0x0E, window_rip 0x1000.
- entry=0x1013. Beats 0-1 dropped, beat 2 written, sub_skip 3 -> count 45, window byte0 = 0x13, window_rip 0x1013.
- Consume 15 per cycle, bus stalled after 2 lines -> count 128 -> 113 -> ... Window contiguous across the 128-byte wrap (bytes 0x7F then 0x80 taken from ring index 0).
- Buffer at count 65: no request issued. Consume to 64 -> req_valid the next cycle.
- Redirect to 0x2008 in WAIT. The remaining 8 beats are acked, count stays 0. Next req_addr=0x2000. Window byte0 = byte 8 of the new line.
- Redirect in the same cycle as consume=5 and a beat write -> count 0, window_rip = redirect_rip, no write recorded.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch queue.
package fetch_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACTIVE} fq_state_e;

    function automatic int beats_per_line(input int line_bytes, input int beat_bytes);
        return line_bytes / beat_bytes;
    endfunction

    function automatic int ptr_width(input int depth_bytes);
        return $clog2(depth_bytes) + 1;
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Bus-side request/response handshake of the fetch queue.
interface fetch_queue_if #(parameter int BEAT_BYTES = 8);
    logic                    req_valid;
    logic [63:0]             req_addr;
    logic                    req_ack;
    logic                    resp_valid;
    logic [8*BEAT_BYTES-1:0] resp_data;
    logic                    resp_ack;

    modport master (output req_valid, req_addr, resp_ack,
                    input  req_ack, resp_valid, resp_data);
    modport slave  (input  req_valid, req_addr, resp_ack,
                    output req_ack, resp_valid, resp_data);
endinterface

// File: rtl/fetch_ring.sv
// Byte ring: one beat-wide write port, one wrapped WINDOW_BYTES-wide read port.
module fetch_ring #(
    parameter int BEAT_BYTES   = 8,
    parameter int DEPTH_BYTES  = 128,
    parameter int WINDOW_BYTES = 15,
    parameter int IW           = $clog2(DEPTH_BYTES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [IW-1:0]             waddr,
    input  logic [8*BEAT_BYTES-1:0]   wdata,
    input  logic [IW-1:0]             raddr,
    output logic [8*WINDOW_BYTES-1:0] window
);
    logic [DEPTH_BYTES-1:0][7:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                mem_d[waddr + IW'(i)] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    // Index arithmetic is IW bits wide, so the window wraps at the ring end.
    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_win
        logic [IW-1:0] idx;
        assign idx = raddr + IW'(i);
        assign window[8*i +: 8] = mem_q[idx];
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: line requests, beat collection into a byte ring,
// decoder window with RIP tracking, redirect with in-flight line discard.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int BEAT_BYTES   = 8,
    parameter int LINE_BYTES   = 64,
    parameter int DEPTH_BYTES  = 128,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [63:0]                        entry,
    fetch_queue_if.master                      bus,
    input  logic                               redirect_valid,
    input  logic [63:0]                        redirect_rip,
    output logic [8*WINDOW_BYTES-1:0]          window,
    output logic                               window_valid,
    output logic [63:0]                        window_rip,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0]  consume,
    output logic [$clog2(DEPTH_BYTES):0]       count
);
    localparam int BPL      = beats_per_line(LINE_BYTES, BEAT_BYTES);
    localparam int AW       = ptr_width(DEPTH_BYTES);
    localparam int IW       = AW - 1;
    localparam int BCW      = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int BEAT_LOG = $clog2(BEAT_BYTES);

    fq_state_e         state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, sub_skip_q, sub_skip_d;
    logic [63:0]       fetch_addr_q, fetch_addr_d, window_rip_q, window_rip_d;
    logic [63:0]       req_addr_q, req_addr_d;
    logic              req_valid_q, req_valid_d, drop_q, drop_d, skip_q, skip_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic              beat, line_end, keep;
    logic [63:0]       skip_beat;

    assign count         = wr_ptr_q - rd_ptr_q;
    assign window_valid  = count >= AW'(WINDOW_BYTES);
    assign window_rip    = window_rip_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.resp_ack  = bus.resp_valid;
    // Until the first beat lands, window_rip still holds the fetch target.
    assign skip_beat     = (window_rip_q & 64'(LINE_BYTES - 1)) >> BEAT_LOG;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sub_skip_d   = sub_skip_q;
        fetch_addr_d = fetch_addr_q;
        window_rip_d = window_rip_q;
        req_addr_d   = req_addr_q;
        req_valid_d  = req_valid_q;
        skip_d       = skip_q;
        beat_cnt_d   = beat_cnt_q;

        beat     = bus.resp_valid && (state_q == S_WAIT || state_q == S_ACTIVE);
        line_end = beat && (beat_cnt_q == BCW'(BPL - 1));
        keep     = beat && !drop_q && !redirect_valid &&
                   (!skip_q || (64'(beat_cnt_q) >= skip_beat));
        drop_d   = (drop_q || (redirect_valid && state_q != S_IDLE)) && !line_end;

        case (state_q)
            S_IDLE: if (!redirect_valid && (AW'(DEPTH_BYTES) - count >= AW'(LINE_BYTES))) begin
                state_d     = S_REQ;
                req_valid_d = 1'b1;
                req_addr_d  = fetch_addr_q & ~64'(LINE_BYTES - 1);
            end
            S_REQ: if (bus.req_ack) begin
                state_d     = S_WAIT;
                req_valid_d = 1'b0;
            end
            S_WAIT:   if (beat) state_d = line_end ? S_IDLE : S_ACTIVE;
            S_ACTIVE: if (line_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (beat) beat_cnt_d = line_end ? '0 : beat_cnt_q + 1'b1;
        if (line_end && !drop_q) fetch_addr_d = fetch_addr_q + 64'(LINE_BYTES);

        if (keep) begin
            wr_ptr_d = wr_ptr_q + AW'(BEAT_BYTES);
            // The RIP's own beat is stored whole; hide its leading bytes.
            if (skip_q) begin
                skip_d   = 1'b0;
                rd_ptr_d = rd_ptr_d + sub_skip_q;
            end
        end

        if (window_valid && !redirect_valid) begin
            rd_ptr_d     = rd_ptr_d + AW'(consume);
            window_rip_d = window_rip_q + 64'(consume);
        end

        if (redirect_valid) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            window_rip_d = redirect_rip;
            fetch_addr_d = redirect_rip;
            sub_skip_d   = AW'(redirect_rip & 64'(BEAT_BYTES - 1));
            skip_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sub_skip_q   <= AW'(entry & 64'(BEAT_BYTES - 1));
            fetch_addr_q <= entry;
            window_rip_q <= entry;
            req_addr_q   <= '0;
            req_valid_q  <= 1'b0;
            drop_q       <= 1'b0;
            skip_q       <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sub_skip_q   <= sub_skip_d;
            fetch_addr_q <= fetch_addr_d;
            window_rip_q <= window_rip_d;
            req_addr_q   <= req_addr_d;
            req_valid_q  <= req_valid_d;
            drop_q       <= drop_d;
            skip_q       <= skip_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    fetch_ring #(
        .BEAT_BYTES  (BEAT_BYTES),
        .DEPTH_BYTES (DEPTH_BYTES),
        .WINDOW_BYTES(WINDOW_BYTES),
        .IW          (IW)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .we    (keep),
        .waddr (wr_ptr_q[IW-1:0]),
        .wdata (bus.resp_data),
        .raddr (rd_ptr_q[IW-1:0]),
        .window(window)
    );

    a_consume_legal: assert property (@(posedge clk) disable iff (reset)
        window_valid |-> int'(consume) <= WINDOW_BYTES);
endmodule
